cq_fifo: RTL and testbench
==========================

# cq_fifo

Synchronous valid/ready FIFO of arbitrary depth, including non-power-of-2 depths. It owns both ends of a circular queue: the enqueue (writer) pointer and the dequeue (reader) pointer, each in flag+value form. Full, empty and occupancy are derived by comparing the two pointers. It is the drop-in buffering primitive for the vector datapath wherever an in-order queue with exposed pointers is needed.

## Interface
- `ENTRIES`, 16, queue depth; legal range ≥ 2, any integer.
- `DATA_WIDTH`, 32, payload width in bits.
- `PTR_WIDTH`, `$clog2(ENTRIES)`, derived; never overridden.

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_ni` in 1: reset, synchronous and active-low.
- `enq_valid_i` in 1: producer offers `enq_data_i`.
- `enq_ready_o` out 1: FIFO accepts; enqueue fires on `enq_valid_i && enq_ready_o`.
- `enq_data_i` in `DATA_WIDTH`: enqueue payload.
- `deq_valid_o` out 1: head entry available.
- `deq_ready_i` in 1: consumer takes head; dequeue fires on `deq_valid_o && deq_ready_i`.
- `deq_data_o` out `DATA_WIDTH`: head payload.
- `full_o` out 1: all `ENTRIES` slots occupied.
- `empty_o` out 1: no slot occupied.
- `count_o` out `PTR_WIDTH+1`: occupancy, 0..`ENTRIES`.
- `enq_ptr_flag_o` out 1, `enq_ptr_value_o` out `PTR_WIDTH`: enqueue pointer.
- `deq_ptr_flag_o` out 1, `deq_ptr_value_o` out `PTR_WIDTH`: dequeue pointer.
- `flush_i` in 1: present only with `CQ_FIFO_FLUSH_EN`; see Configuration.

## Operation
**Storage**
- `ENTRIES` × `DATA_WIDTH` register array. It is not reset.
- An enqueue writes slot `enq_ptr_value`.
- `deq_data_o` = slot `deq_ptr_value`, read combinationally.

**Pointer increment** (applied on a fire)
- Non-power-of-2 `ENTRIES`: if value == `ENTRIES-1`, value becomes 0 and the flag toggles; otherwise value +1.
- Power-of-2 `ENTRIES`: `{flag,value}+1`, which produces the same sequence.

**Status**
- `empty_o` = flags equal and values equal.
- `full_o` = flags differ and values equal.
- `enq_ready_o` = `!full_o`.
- `deq_valid_o` = `!empty_o`.
- `count_o`:
  - flags equal: `enq_value - deq_value`;
  - flags differ: `ENTRIES - deq_value + enq_value`.
  - Computed at `PTR_WIDTH+1` bits, with no truncation loss.

**Boundary conditions**
- Simultaneous enqueue and dequeue fire: both pointers advance; count is unchanged.
- Full: enqueue is blocked; a dequeue may still fire.
- Empty: dequeue is blocked; an enqueue may fire.
- No same-cycle fall-through: data enqueued into an empty FIFO appears one cycle later.
- `deq_data_o` is don't-care while `empty_o`=1.
- Wrap-around of either pointer at value `ENTRIES-1` behaves as defined above for any depth.

## Timing
- Reset, applied while `rst_ni`=0 at a rising edge:
  - both pointers become flag 0 / value 0;
  - `empty_o`=1, `full_o`=0, `count_o`=0;
  - `enq_ready_o`=1, `deq_valid_o`=0.
- Reset mid-operation discards all contents at that edge. Any handshake in the same cycle is ignored.
- Enqueue-to-dequeue latency: 1 cycle.
- Throughput: 1 enqueue plus 1 dequeue per cycle.
- All outputs are functions of registered pointers. The one exception is the flush gating below.
- Neither `enq_ready_o` nor `deq_valid_o` depends combinationally on `enq_valid_i` or `deq_ready_i`.

## Configuration
- `CQ_FIFO_FLUSH_EN` defined:
  - the `flush_i` port exists;
  - `flush_i`=1 forces `enq_ready_o`=0 and `deq_valid_o`=0 combinationally in that cycle;
  - at the next edge both pointers return to flag 0 / value 0 (the FIFO becomes empty);
  - flush has priority over any handshake in the same cycle; reset has priority over flush.
- `CQ_FIFO_FLUSH_EN` undefined:
  - no `flush_i` port and no flush logic;
  - contents are cleared only by reset.

## Test plan
- **Reset defaults:** hold `rst_ni`=0 for 2 cycles, then release → `empty_o`=1, `full_o`=0, `count_o`=0, `enq_ready_o`=1, `deq_valid_o`=0, all pointer outputs 0.
- **Fill and drain:** `ENTRIES`=4; enqueue 0xA0..0xA3 on consecutive cycles →
  - `full_o`=1, `count_o`=4, `enq_ready_o`=0, enq ptr flag 1 / value 0;
  - a 5th enqueue attempt (0xA4) is not accepted;
  - draining returns 0xA0, 0xA1, 0xA2, 0xA3 in order, then `empty_o`=1.
- **Non-power-of-2 wrap:** `ENTRIES`=5; 7 back-to-back cycles of enqueue-then-dequeue traffic →
  - both pointers reach flag 1 / value 2;
  - `count_o` never exceeds 1;
  - every dequeued datum matches its enqueue.
- **Simultaneous fire:** `ENTRIES`=5 at `count_o`=2; assert enqueue and dequeue together for 3 cycles → `count_o` stays 2 and data order is preserved. At full, assert both → only the dequeue fires and `count_o` becomes 4.
- **Mid-operation reset:** `count_o`=3 with `enq_valid_i`=1 and `deq_ready_i`=1; drive `rst_ni`=0 for one edge → `count_o`=0, pointers 0, `empty_o`=1; the next enqueue lands in slot 0.
- **Flush** (`CQ_FIFO_FLUSH_EN`): `count_o`=3; assert `flush_i` together with an enqueue of 0x55 →
  - in that cycle, `enq_ready_o`=0 and `deq_valid_o`=0;
  - the next cycle shows `empty_o`=1 and `count_o`=0, and 0x55 is never dequeued.

Source files
------------

// File: rtl/cq_fifo_if.sv
// cq_fifo_if: handshake, status and pointer bundle for cq_fifo.
interface cq_fifo_if #(
  parameter int ENTRIES = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int PTR_WIDTH = $clog2(ENTRIES);
  logic                  enq_valid_i;
  logic                  enq_ready_o;
  logic [DATA_WIDTH-1:0] enq_data_i;
  logic                  deq_valid_o;
  logic                  deq_ready_i;
  logic [DATA_WIDTH-1:0] deq_data_o;
  logic                  full_o;
  logic                  empty_o;
  logic [PTR_WIDTH:0]    count_o;
  logic                  enq_ptr_flag_o;
  logic [PTR_WIDTH-1:0]  enq_ptr_value_o;
  logic                  deq_ptr_flag_o;
  logic [PTR_WIDTH-1:0]  deq_ptr_value_o;
  modport master (
    output enq_valid_i, enq_data_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_data_o, full_o, empty_o, count_o,
           enq_ptr_flag_o, enq_ptr_value_o, deq_ptr_flag_o, deq_ptr_value_o
  );
  modport slave (
    input  enq_valid_i, enq_data_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_data_o, full_o, empty_o, count_o,
           enq_ptr_flag_o, enq_ptr_value_o, deq_ptr_flag_o, deq_ptr_value_o
  );
endinterface

// File: rtl/cq_fifo.sv
// cq_fifo: circular-queue valid/ready FIFO of any depth with flag+value pointers.
// Optional synchronous flush port enabled by defining CQ_FIFO_FLUSH_EN.
module cq_fifo #(
  parameter int ENTRIES = 16,
  parameter int DATA_WIDTH = 32,
  localparam int PTR_WIDTH = $clog2(ENTRIES)
) (
  input logic clk_i,
  input logic rst_ni,
`ifdef CQ_FIFO_FLUSH_EN
  input logic flush_i,
`endif
  cq_fifo_if.slave io
);
  localparam bit POW2 = (ENTRIES == (1 << PTR_WIDTH));
  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(ENTRIES - 1);
  localparam logic [PTR_WIDTH:0] DEPTH = (PTR_WIDTH + 1)'(ENTRIES);
  typedef struct packed {
    logic                 flag;
    logic [PTR_WIDTH-1:0] value;
  } ptr_t;
  ptr_t enq_ptr, deq_ptr;
  logic [DATA_WIDTH-1:0] mem [ENTRIES];
  logic same_flag, same_val, full, empty, flush, enq_fire, deq_fire;
  function automatic ptr_t inc(ptr_t p);
    inc = p;
    if (POW2) inc = ptr_t'(p + 1'b1);
    else if (p.value == LAST) begin
      inc.flag  = ~p.flag;
      inc.value = '0;
    end else inc.value = p.value + 1'b1;
  endfunction
`ifdef CQ_FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif
  assign same_flag = enq_ptr.flag == deq_ptr.flag;
  assign same_val  = enq_ptr.value == deq_ptr.value;
  assign empty     = same_flag && same_val;
  assign full      = !same_flag && same_val;
  assign io.full_o      = full;
  assign io.empty_o     = empty;
  assign io.enq_ready_o = !full && !flush;
  assign io.deq_valid_o = !empty && !flush;
  // Modular add: differing flags mean the writer has wrapped once ahead of the reader.
  assign io.count_o = (same_flag ? '0 : DEPTH) + {1'b0, enq_ptr.value} - {1'b0, deq_ptr.value};
  assign io.deq_data_o      = mem[deq_ptr.value];
  assign io.enq_ptr_flag_o  = enq_ptr.flag;
  assign io.enq_ptr_value_o = enq_ptr.value;
  assign io.deq_ptr_flag_o  = deq_ptr.flag;
  assign io.deq_ptr_value_o = deq_ptr.value;
  assign enq_fire = io.enq_valid_i && io.enq_ready_o;
  assign deq_fire = io.deq_valid_o && io.deq_ready_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
    end else begin
      if (enq_fire) enq_ptr <= inc(enq_ptr);
      if (deq_fire) deq_ptr <= inc(deq_ptr);
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[enq_ptr.value] <= io.enq_data_i;
  end
endmodule

// File: tb/tb_cq_fifo.sv
// tb_cq_fifo: runs a depth-4 and a depth-5 cq_fifo side by side against an occupancy/count model.
module tb_cq_fifo;
  logic clk = 1'b0, rst_n = 1'b0, ev = 1'b0, dr = 1'b0, fl = 1'b0;
  logic [31:0] ed = '0;
  int checks = 0, errors = 0;
  int ne[2], nd[2];
  logic [31:0] sb[2][64];
  logic o_er[2], o_dv[2], o_full[2], o_empty[2], o_ef[2], o_df[2];
  logic [3:0] o_cnt[2], o_ev[2], o_dp[2];
  logic [31:0] o_dat[2];
  always #5 clk = ~clk;
  cq_fifo_if #(.ENTRIES(4), .DATA_WIDTH(32)) a ();
  cq_fifo_if #(.ENTRIES(5), .DATA_WIDTH(32)) b ();
  assign a.enq_valid_i = ev;
  assign a.enq_data_i  = ed;
  assign a.deq_ready_i = dr;
  assign b.enq_valid_i = ev;
  assign b.enq_data_i  = ed;
  assign b.deq_ready_i = dr;
  cq_fifo #(.ENTRIES(4), .DATA_WIDTH(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef CQ_FIFO_FLUSH_EN
    .flush_i(fl),
`endif
    .io(a)
  );
  cq_fifo #(.ENTRIES(5), .DATA_WIDTH(32)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef CQ_FIFO_FLUSH_EN
    .flush_i(fl),
`endif
    .io(b)
  );
  assign o_er[0] = a.enq_ready_o;
  assign o_dv[0] = a.deq_valid_o;
  assign o_full[0] = a.full_o;
  assign o_empty[0] = a.empty_o;
  assign o_ef[0] = a.enq_ptr_flag_o;
  assign o_df[0] = a.deq_ptr_flag_o;
  assign o_cnt[0] = 4'(a.count_o);
  assign o_ev[0] = 4'(a.enq_ptr_value_o);
  assign o_dp[0] = 4'(a.deq_ptr_value_o);
  assign o_dat[0] = a.deq_data_o;
  assign o_er[1] = b.enq_ready_o;
  assign o_dv[1] = b.deq_valid_o;
  assign o_full[1] = b.full_o;
  assign o_empty[1] = b.empty_o;
  assign o_ef[1] = b.enq_ptr_flag_o;
  assign o_df[1] = b.deq_ptr_flag_o;
  assign o_cnt[1] = 4'(b.count_o);
  assign o_ev[1] = 4'(b.enq_ptr_value_o);
  assign o_dp[1] = 4'(b.deq_ptr_value_o);
  assign o_dat[1] = b.deq_data_o;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Pointers are the fire counts since the last clear, taken modulo 2*ENTRIES.
  task automatic step();
    bit ef[2], df[2];
    #1;
    for (int d = 0; d < 2; d++) begin
      int e, occ, pe, pd;
      e = d ? 5 : 4;
      occ = ne[d] - nd[d];
      pe = ne[d] % (2 * e);
      pd = nd[d] % (2 * e);
      chk($sformatf("d%0d count", d), 32'(o_cnt[d]), occ);
      chk($sformatf("d%0d empty", d), 32'(o_empty[d]), 32'(occ == 0));
      chk($sformatf("d%0d full", d), 32'(o_full[d]), 32'(occ == e));
      chk($sformatf("d%0d enq_ready", d), 32'(o_er[d]), 32'(occ != e && !fl));
      chk($sformatf("d%0d deq_valid", d), 32'(o_dv[d]), 32'(occ != 0 && !fl));
      chk($sformatf("d%0d enq_flag", d), 32'(o_ef[d]), 32'(pe >= e));
      chk($sformatf("d%0d enq_value", d), 32'(o_ev[d]), pe % e);
      chk($sformatf("d%0d deq_flag", d), 32'(o_df[d]), 32'(pd >= e));
      chk($sformatf("d%0d deq_value", d), 32'(o_dp[d]), pd % e);
      if (occ != 0) chk($sformatf("d%0d deq_data", d), o_dat[d], sb[d][nd[d] % 64]);
      ef[d] = ev && occ != e && !fl;
      df[d] = dr && occ != 0 && !fl;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || fl) begin
        ne[d] = 0;
        nd[d] = 0;
      end else begin
        if (ef[d]) begin
          sb[d][ne[d] % 64] = ed;
          ne[d]++;
        end
        if (df[d]) nd[d]++;
      end
    end
    @(negedge clk);
  endtask
  task automatic cyc(logic r, logic v, logic [31:0] dat, logic rd);
    rst_n = r;
    ev = v;
    ed = dat;
    dr = rd;
    step();
  endtask
  initial begin
    ne = '{0, 0};
    nd = '{0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'hA0 + i, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 32'hB0 + i, 0);
      cyc(1, 0, 0, 1);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 1, 32'hC0, 0);
    cyc(1, 1, 32'hC1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hC2 + i, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hD0 + i, 0);
    cyc(1, 1, 32'hDD, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hE0 + i, 0);
    cyc(0, 1, 32'hEE, 1);
    cyc(1, 1, 32'hF0, 0);
    cyc(1, 0, 0, 0);
`ifdef CQ_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h40 + i, 0);
    fl = 1'b1;
    cyc(1, 1, 32'h55, 1);
    fl = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
`endif
    for (int i = 0; i < 600; i++) begin
`ifdef CQ_FIFO_FLUSH_EN
      fl = ($urandom_range(31) == 0);
`endif
      cyc($urandom_range(63) != 0, $urandom_range(99) < 55, $urandom, $urandom_range(99) < 50);
    end
    fl = 1'b0;
    cyc(1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
